serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial 4-bit subtractor: x - y - borrow_in, one bit per clock, LSB (index 0) first.
// A single full-adder cell adds x + ~y + ~borrow_in; results are published only when bit 3 completes.
module serial_subtractor (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [0:3] x,
  input  logic [0:3] y,
  input  logic       borrow_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [0:3] diff,
  output logic       borrow_out,
  output logic       overflow
);

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [0:W-1]    r_x;
  logic [0:W-1]    r_y;
  logic            r_c;
  logic [IW-1:0]   r_idx;
  logic [0:W-1]    r_diff_sh;
  logic            r_c3;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [0:W-1]    r_diff;
  logic            r_borrow;
  logic            r_ovf;

  // Full-adder cell on the current LSB of the shift registers
  logic w_yn;
  logic w_s;
  logic w_cn;

  assign w_yn = ~r_y[0];
  assign w_s  = r_x[0] ^ w_yn ^ r_c;
  assign w_cn = (r_x[0] & w_yn) | (r_x[0] & r_c) | (w_yn & r_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_c       <= 1'b0;
      r_idx     <= '0;
      r_diff_sh <= '0;
      r_c3      <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_diff    <= '0;
      r_borrow  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_c     <= ~borrow_in;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Shift operands toward index 0; sum bits enter at index 3 so bit 0 lands at index 0
          r_x       <= {r_x[1:W-1], 1'b0};
          r_y       <= {r_y[1:W-1], 1'b0};
          r_c       <= w_cn;
          r_diff_sh <= {r_diff_sh[1:W-1], w_s};
          r_idx     <= r_idx + IW'(1);
          if (r_idx == IW'(2)) begin
            r_c3 <= w_cn;
          end
          if (r_idx == IW'(3)) begin
            r_diff   <= {r_diff_sh[1:W-1], w_s};
            r_borrow <= ~w_cn;
            r_ovf    <= r_c3 ^ w_cn;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of modelled results, checked per scenario task.
module tb_serial_subtractor;

  typedef struct packed {
    logic [3:0] d;
    logic       b;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [0:3] x;
  logic [0:3] y;
  logic       borrow_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic [0:3] diff;
  logic       borrow_out;
  logic       overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_last_diff = 0;
  exp_t sb[$];

  serial_subtractor dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x          (x),
    .y          (y),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Index 0 of a [0:3] vector carries the integer LSB
  function automatic logic [0:3] to_vec(input int v);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic int from_vec(input logic [0:3] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic exp_t model(input int xv, input int yv, input int bv);
    exp_t e;
    int sx, sy, sd;
    e.d = 4'((xv - yv - bv) & 15);
    e.b = (xv < yv + bv);
    sx  = (xv >= 8) ? xv - 16 : xv;
    sy  = (yv >= 8) ? yv - 16 : yv;
    sd  = sx - sy - bv;
    e.o = (sd < -8) || (sd > 7);
    return e;
  endfunction

  task automatic check_result(input string nm);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: done with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      exp_last_diff = int'(e.d);
      n_checks += 2;
      if (from_vec(diff) !== int'(e.d)) begin
        n_fail++;
        $display("FAIL %s diff: got %0d expected %0d", nm, from_vec(diff), e.d);
      end
      if (borrow_out !== e.b) begin
        n_fail++;
        $display("FAIL %s borrow_out: got %b expected %b", nm, borrow_out, e.b);
      end
      if (overflow !== e.o) begin
        n_fail++;
        $display("FAIL %s overflow: got %b expected %b", nm, overflow, e.o);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; x = '0; y = '0; borrow_in = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_last_diff = 0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || from_vec(diff) !== 0 ||
        borrow_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b busy=%b done=%b diff=%0d bo=%b ov=%b expected 1 0 0 0 0 0",
               ready, busy, done, from_vec(diff), borrow_out, overflow);
    end
  endtask

  task automatic run_op(input int xv, input int yv, input int bv, input string nm);
    int cyc;
    bit seen;
    x = to_vec(xv); y = to_vec(yv); borrow_in = bv[0]; start = 1'b1;
    sb.push_back(model(xv, yv, bv));
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    x = ~x; y = ~y; borrow_in = ~borrow_in;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: got busy=%b ready=%b expected 1 0", nm, busy, ready);
    end
    cyc = 0; seen = 0;
    while (!seen && cyc < 10) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        n_checks++;
        if (from_vec(diff) !== exp_last_diff) begin
          n_fail++;
          $display("FAIL %s hold: got diff=%0d expected %0d at cycle %0d", nm, from_vec(diff), exp_last_diff, cyc);
        end
      end
    end
    n_checks++;
    if (!seen || cyc != 4) begin
      n_fail++;
      $display("FAIL %s latency: got done at cycle %0d (seen=%0d) expected 4", nm, cyc, seen);
    end
    if (seen) check_result(nm);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return_idle: got rdy=%b done=%b busy=%b expected 1 0 0", nm, ready, done, busy);
    end
  endtask

  task automatic test_basic();
    run_op(5, 3, 0, "basic_5_3");
    n_checks += 2;
    if (diff[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_bit0: got %b expected 0", diff[0]);
    end
    if (diff[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_bit1: got %b expected 1", diff[1]);
    end
  endtask

  task automatic test_borrow();
    run_op(3, 5, 0, "unsigned_borrow");
    run_op(8, 1, 0, "signed_overflow");
    run_op(0, 0, 1, "borrow_in");
    run_op(7, 8, 1, "overflow_pos");
    run_op(15, 15, 0, "zero_result");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int xv, yv, bv;
      xv = int'($urandom_range(0, 15));
      yv = int'($urandom_range(0, 15));
      bv = int'($urandom_range(0, 1));
      run_op(xv, yv, bv, "random");
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int first_at, second_at;
    n_done = 0; first_at = -1; second_at = -1;
    x = to_vec(9); y = to_vec(4); borrow_in = 1'b0; start = 1'b1;
    sb.push_back(model(9, 4, 0));
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        x = to_vec(1); y = to_vec(1);
        sb.push_back(model(1, 1, 0));
      end
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) first_at = c;
        else if (n_done == 2) second_at = c;
        check_result("back_to_back");
      end
      if (c == 11) start = 1'b0;
    end
    n_checks += 2;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d expected 2", n_done);
    end
    if (first_at != 4 || second_at != 10) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got %0d,%0d expected 4,10", first_at, second_at);
    end
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    x = to_vec(7); y = to_vec(2); borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_last_diff = 0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || from_vec(diff) !== 0 ||
        borrow_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_values: got rdy=%b busy=%b done=%b diff=%0d bo=%b ov=%b expected 1 0 0 0 0 0",
               ready, busy, done, from_vec(diff), borrow_out, overflow);
    end
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", n_done);
    end
    run_op(7, 2, 0, "after_abort");
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; x = to_vec(4); y = to_vec(1); borrow_in = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: got rdy=%b busy=%b expected 1 0", ready, busy);
    end
    reset = 1'b0;
    exp_last_diff = 0;
    start = 1'b0;
    run_op(4, 1, 0, "after_priority");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x = '0; y = '0; borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_reset_priority();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
